// File: rtl/score_pkg.sv
// Shared constants and types for the multi-player bowling score keeper:
// seven-segment patterns, pin clamp limit and the BCD converter state set.
package score_pkg;

    localparam int MAX_PINS = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Non-decimal nibbles map to blank rather than indexing past the table.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_DIGIT[i];
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter that re-renders the seven-segment display
// whenever the presented binary value differs from the last one converted.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = 9,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SCORE_W-1:0]    value_i,
    output logic                  busy_o,
    output logic [7*DIGITS-1:0]   hex_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(SCORE_W + 1);
    localparam logic [7*DIGITS-1:0] HEX_RESET = ~((7*DIGITS)'(7'b0111111));

    conv_state_t          state_q;
    conv_state_t          state_d;
    logic [SCORE_W-1:0]   cap_q;
    logic [SCORE_W-1:0]   cap_d;
    logic [SCORE_W-1:0]   last_q;
    logic [SCORE_W-1:0]   last_d;
    logic [SCORE_W-1:0]   bin_q;
    logic [SCORE_W-1:0]   bin_d;
    logic [BW-1:0]        bcd_q;
    logic [BW-1:0]        bcd_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 busy_q;
    logic                 busy_d;
    logic [7*DIGITS-1:0]  hex_q;
    logic [7*DIGITS-1:0]  hex_d;

    logic [BW-1:0]        bcd_adj;
    logic [7*DIGITS-1:0]  seg_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
            if (gi == 0) begin : g_units
                assign seg_next[6:0] = seg_encode(bcd_q[3:0]);
            end else begin : g_upper
                // Blank unless this digit or any more significant one is nonzero.
                assign seg_next[gi*7 +: 7] = (|bcd_q[BW-1:gi*4]) ?
                                             seg_encode(bcd_q[gi*4 +: 4]) : SEG_BLANK;
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        last_d  = last_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hex_d   = hex_q;
        case (state_q)
            IDLE: begin
                if (value_i != last_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cap_d   = value_i;
                bin_d   = value_i;
                bcd_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(SCORE_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hex_d   = seg_next;
                last_d  = cap_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            last_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hex_q   <= HEX_RESET;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hex_q   <= hex_d;
        end
    end

    assign busy_o = busy_q;
    assign hex_o  = hex_q;

endmodule

// File: rtl/button_cond.sv
// Button conditioner: 2-flop synchroniser, stability debounce and a one-cycle
// event on each debounced press (1->0) of an active-low button.
module button_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Counter only advances on consecutive samples that disagree with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/multi_player_score.sv
// Multi-player bowling score keeper: debounced hit / end-of-turn buttons,
// per-player saturating scores and a BCD seven-segment view of the active player.
module multi_player_score
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_W         = 9,
    parameter int MAX_SCORE       = 300,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                             CLOCK_50,
    input  logic                             RESET_N,
    input  logic                             HIT_N,
    input  logic                             NEXT_N,
    input  logic [3:0]                       PINS,
    input  logic                             CLEAR,
    output logic [$clog2(NUM_PLAYERS)-1:0]   ACTIVE_PLAYER,
    output logic [NUM_PLAYERS*SCORE_W-1:0]   SCORES,
    output logic                             SAT,
    output logic [DIGITS*7-1:0]              HEX,
    output logic                             BUSY
);

    localparam int AW = $clog2(NUM_PLAYERS);

    logic [1:0]                     btn_n;
    logic [1:0]                     press;
    logic                           hit_ev;
    logic                           next_ev;
    logic [3:0]                     pins_clamped;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_flat;
    logic [SCORE_W-1:0]             active_score;
    logic [AW-1:0]                  active_q;
    logic [AW-1:0]                  active_d;

    assign btn_n   = {NEXT_N, HIT_N};
    assign hit_ev  = press[0];
    assign next_ev = press[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            button_cond #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk     (CLOCK_50),
                .rst_n   (RESET_N),
                .btn_n_i (btn_n[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    assign pins_clamped = (PINS > 4'(MAX_PINS)) ? 4'(MAX_PINS) : PINS;

    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [SCORE_W-1:0] score_q;
            logic [SCORE_W-1:0] score_d;
            logic [SCORE_W:0]   sum;

            // One extra bit keeps the sum from wrapping before saturation.
            assign sum = {1'b0, score_q} + (SCORE_W+1)'(pins_clamped);

            always_comb begin
                score_d = score_q;
                if (CLEAR) begin
                    score_d = '0;
                end else if (hit_ev && (active_q == AW'(gi))) begin
                    score_d = (sum > (SCORE_W+1)'(MAX_SCORE)) ?
                              SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
                end
            end

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    score_q <= '0;
                end else begin
                    score_q <= score_d;
                end
            end

            assign scores_flat[gi*SCORE_W +: SCORE_W] = score_q;
        end
    endgenerate

    // A hit in the same cycle as a next is credited before the advance,
    // because the score path above decodes the pre-advance player index.
    always_comb begin
        active_d = active_q;
        if (CLEAR) begin
            active_d = '0;
        end else if (next_ev) begin
            active_d = (active_q == AW'(NUM_PLAYERS - 1)) ? '0 : active_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end

    always_comb begin
        active_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active_q == AW'(i)) begin
                active_score = scores_flat[i*SCORE_W +: SCORE_W];
            end
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .value_i (active_score),
        .busy_o  (BUSY),
        .hex_o   (HEX)
    );

    assign ACTIVE_PLAYER = active_q;
    assign SCORES        = scores_flat;
    assign SAT           = (active_score == SCORE_W'(MAX_SCORE));

endmodule

// File: tb/tb_multi_player_score.sv
// Randomized self-checking bench for multi_player_score against a plain
// arithmetic model of scores, turn rotation and the decimal display.
module tb_multi_player_score;

    localparam int NP   = 3;
    localparam int SW   = 9;
    localparam int MAXS = 300;
    localparam int DG   = 3;
    localparam int DB   = 4;
    localparam int AW   = $clog2(NP);

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N  = 1'b0;
    logic              HIT_N    = 1'b1;
    logic              NEXT_N   = 1'b1;
    logic [3:0]        PINS     = 4'd0;
    logic              CLEAR    = 1'b0;
    logic [AW-1:0]     ACTIVE_PLAYER;
    logic [NP*SW-1:0]  SCORES;
    logic              SAT;
    logic [DG*7-1:0]   HEX;
    logic              BUSY;

    multi_player_score #(
        .NUM_PLAYERS     (NP),
        .SCORE_W         (SW),
        .MAX_SCORE       (MAXS),
        .DIGITS          (DG),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .HIT_N         (HIT_N),
        .NEXT_N        (NEXT_N),
        .PINS          (PINS),
        .CLEAR         (CLEAR),
        .ACTIVE_PLAYER (ACTIVE_PLAYER),
        .SCORES        (SCORES),
        .SAT           (SAT),
        .HEX           (HEX),
        .BUSY          (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;
    int m_score [NP];
    int m_active = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [DG*7-1:0] model_hex(input int v);
        logic [DG*7-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DG; i++) begin
            if (i > 0 && v < p) r[i*7 +: 7] = 7'b1111111;
            else                r[i*7 +: 7] = seg7((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [NP*SW-1:0] model_flat();
        logic [NP*SW-1:0] f;
        f = '0;
        for (int i = 0; i < NP; i++) f[i*SW +: SW] = SW'(m_score[i]);
        return f;
    endfunction

    task automatic check_all(input string tag);
        $display("txn %s: active=%0d scores=%h hex=%h", tag, ACTIVE_PLAYER, SCORES, HEX);
        check_eq({tag, ".scores"}, 64'(SCORES), 64'(model_flat()));
        check_eq({tag, ".active"}, 64'(ACTIVE_PLAYER), 64'(m_active));
        check_eq({tag, ".sat"}, 64'(SAT), 64'(m_score[m_active] == MAXS));
        check_eq({tag, ".hex"}, 64'(HEX), 64'(model_hex(m_score[m_active])));
        check_eq({tag, ".busy"}, 64'(BUSY), 64'd0);
    endtask

    task automatic model_hit(input int p);
        int c;
        c = (p > 10) ? 10 : p;
        m_score[m_active] = (m_score[m_active] + c > MAXS) ? MAXS : m_score[m_active] + c;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_active = 0;
    endtask

    task automatic settle();
        repeat (SW + 8) @(negedge CLOCK_50);
    endtask

    task automatic do_hit(input int p, input int hold);
        @(negedge CLOCK_50);
        PINS  = 4'(p);
        HIT_N = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        HIT_N = 1'b1;
        repeat (DB + 4) @(negedge CLOCK_50);
        model_hit(p);
        settle();
    endtask

    task automatic do_next(input int hold);
        @(negedge CLOCK_50);
        NEXT_N = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        NEXT_N = 1'b1;
        repeat (DB + 4) @(negedge CLOCK_50);
        m_active = (m_active + 1) % NP;
        settle();
    endtask

    task automatic do_glitch(input int which, input int hold);
        @(negedge CLOCK_50);
        PINS = 4'($urandom_range(1, 15));
        if (which == 0) HIT_N = 1'b0; else NEXT_N = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        HIT_N  = 1'b1;
        NEXT_N = 1'b1;
        settle();
    endtask

    task automatic do_clear();
        @(negedge CLOCK_50);
        CLEAR = 1'b1;
        @(negedge CLOCK_50);
        CLEAR = 1'b0;
        model_clear();
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        int pv;
        for (int i = 0; i < NP; i++) m_score[i] = 0;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check_all("reset");
        check_eq("reset.hex_raw", 64'(HEX), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // Press-to-score latency and single add while held
        @(negedge CLOCK_50);
        PINS  = 4'd7;
        HIT_N = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        #1 check_eq("lat.before", 64'(SCORES[SW-1:0]), 64'd0);
        @(posedge CLOCK_50);
        #1 check_eq("lat.at7", 64'(SCORES[SW-1:0]), 64'd7);
        repeat (SW + 2) @(posedge CLOCK_50);
        #1 check_eq("hexlat.before", 64'(HEX[6:0]), 64'(7'b1000000));
        @(posedge CLOCK_50);
        #1 check_eq("hexlat.at", 64'(HEX[6:0]), 64'(7'b1111000));
        @(negedge CLOCK_50);
        HIT_N = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        m_score[0] = 7;
        check_all("hold20");

        // Short glitch must be filtered
        busy_seen = 0;
        @(negedge CLOCK_50);
        PINS  = 4'd9;
        HIT_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        HIT_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK_50);
            if (BUSY) busy_seen++;
        end
        check_eq("glitch.busy_seen", 64'(busy_seen), 64'd0);
        check_all("glitch");

        // Rotation and pin clamping
        do_next(6);
        do_hit(15, 6);
        check_all("p1_clamp");
        check_eq("p1.hex_raw", 64'(HEX), 64'({7'b1111111, 7'b1111001, 7'b1000000}));
        do_next(DB + 2);
        check_all("next2");
        do_next(DB + 5);
        check_all("wrap");

        // Saturation
        for (int k = 0; k < 31; k++) begin
            do_hit(10, DB + 1);
            check_all($sformatf("sat%0d", k));
        end
        check_eq("sat.score", 64'(SCORES[SW-1:0]), 64'd300);
        check_eq("sat.hex_raw", 64'(HEX), 64'({7'b0110000, 7'b1000000, 7'b1000000}));
        do_hit(10, DB + 2);
        check_all("sat_extra");

        // Clear during conversion, coinciding with a hit event
        @(negedge CLOCK_50);
        PINS   = 4'd5;
        NEXT_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        HIT_N = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        check_eq("clr.busy_before", 64'(BUSY), 64'd1);
        CLEAR = 1'b1;
        @(negedge CLOCK_50);
        CLEAR = 1'b0;
        check_eq("clr.scores_now", 64'(SCORES), 64'd0);
        check_eq("clr.active_now", 64'(ACTIVE_PLAYER), 64'd0);
        repeat (4) @(negedge CLOCK_50);
        HIT_N  = 1'b1;
        NEXT_N = 1'b1;
        model_clear();
        repeat (45) @(negedge CLOCK_50);
        check_all("clear_busy");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                pv = $urandom_range(0, 15);
                do_hit(pv, DB + $urandom_range(0, 7));
                check_all($sformatf("rnd%0d.hit%0d", t, pv));
            end else if (r <= 6) begin
                do_next(DB + $urandom_range(0, 7));
                check_all($sformatf("rnd%0d.next", t));
            end else if (r <= 8) begin
                do_glitch($urandom_range(0, 1), $urandom_range(1, DB - 1));
                check_all($sformatf("rnd%0d.glitch", t));
            end else begin
                do_clear();
                check_all($sformatf("rnd%0d.clear", t));
            end
        end

        // Asynchronous reset in the middle of a conversion
        do_clear();
        do_hit(8, DB + 1);
        check_all("pre_reset");
        @(negedge CLOCK_50);
        PINS  = 4'd3;
        HIT_N = 1'b0;
        for (int k = 0; k < 40 && !BUSY; k++) @(negedge CLOCK_50);
        check_eq("rst.busy_seen", 64'(BUSY), 64'd1);
        #2 RESET_N = 1'b0;
        #1;
        model_clear();
        check_all("async_reset");
        check_eq("rst.hex_raw", 64'(HEX), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
        HIT_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
